// File: rtl/rs232_rx_param.sv
// rs232_rx_param: parametrised RS-232 receiver with 3-sample majority vote and a valid/ready output.
// Define RS232_RX_PARITY_EN to compile in the parity bit and the ParityError flag.
module rs232_rx_param #(
    parameter int SampleDiv = 3,
    parameter int DivBits   = 8,
    parameter int DataBits  = 8,
    parameter int StopBits  = 1,
    parameter int ParityOdd = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Rx,
    output logic [DataBits-1:0] RxData,
    output logic                RxValid,
    input  logic                RxReady,
    output logic                FrameError,
    output logic                ParityError,
    output logic                Break,
    output logic                Overrun,
    output logic                Busy
);

    if (SampleDiv < 1 || (SampleDiv - 1) >= (1 << DivBits) || DataBits < 5 || DataBits > 9 ||
        StopBits < 1 || StopBits > 2 || ParityOdd < 0 || ParityOdd > 1) begin : g_bad_params
        $error("rs232_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT} state_t;

    localparam logic [DivBits-1:0] DivLast     = DivBits'(SampleDiv - 1);
    localparam logic [3:0]         LastDataIdx = 4'(DataBits - 1);
    localparam logic [3:0]         LastStopIdx = 4'(StopBits - 1);

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic [DivBits-1:0]  div_q, div_d;
    logic [3:0]          tick_cnt_q, tick_cnt_d;
    logic [1:0]          smp_q, smp_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                stop_low_q, stop_low_d;
    logic                first_stop_low_q, first_stop_low_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                fe_q, fe_d;
    logic                pe_q, pe_d;
    logic                brk_q, brk_d;
    logic                ovr_q, ovr_d;
    logic                busy_q, busy_d;
`ifdef RS232_RX_PARITY_EN
    localparam logic ParOdd = (ParityOdd != 0);
    logic                par_bit_q, par_bit_d;
`endif

    logic s, tick, vote, vote_now, commit, accept;
    logic frame_fe, frame_pe, frame_brk, par_zero, first_stop_low;

    always_comb begin
        rx_meta_d        = Rx;
        rx_sync_d        = rx_meta_q;
        s                = rx_sync_q;
        state_d          = state_q;
        div_d            = div_q;
        tick_cnt_d       = tick_cnt_q;
        smp_d            = smp_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        stop_low_d       = stop_low_q;
        first_stop_low_d = first_stop_low_q;
        data_d           = data_q;
        valid_d          = valid_q;
        fe_d             = fe_q;
        pe_d             = pe_q;
        brk_d            = brk_q;
        ovr_d            = 1'b0;
        commit           = 1'b0;
        vote_now         = 1'b0;
        accept           = valid_q && RxReady;
        tick             = (div_q == DivLast);
        vote             = (smp_q[0] & smp_q[1]) | (smp_q[0] & s) | (smp_q[1] & s);
`ifdef RS232_RX_PARITY_EN
        par_bit_d        = par_bit_q;
        par_zero         = ~par_bit_q;
        frame_pe         = par_bit_q ^ (^shift_q) ^ ParOdd;
`else
        par_zero         = 1'b1;
        frame_pe         = 1'b0;
`endif
        first_stop_low   = (bit_cnt_q == 4'd0) ? ~vote : first_stop_low_q;
        frame_fe         = stop_low_q | ~vote;
        frame_brk        = (shift_q == '0) & par_zero & first_stop_low;

        // Counters idle at zero so the bit phase starts exactly on the detected start edge.
        if (state_q == IDLE || state_q == WAIT) begin
            div_d      = '0;
            tick_cnt_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + DivBits'(1);
            if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd7) smp_d[0] = s;
                if (tick_cnt_q == 4'd8) smp_d[1] = s;
                vote_now = (tick_cnt_q == 4'd9);
            end
        end

        case (state_q)
            IDLE: if (!s) state_d = START;
            START: if (vote_now) begin
                if (!vote) begin
                    state_d          = DATA;
                    bit_cnt_d        = '0;
                    stop_low_d       = 1'b0;
                    first_stop_low_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (vote_now) begin
                shift_d = {vote, shift_q[DataBits-1:1]};
                if (bit_cnt_q == LastDataIdx) begin
                    bit_cnt_d = '0;
`ifdef RS232_RX_PARITY_EN
                    state_d   = PARITY;
`else
                    state_d   = STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`ifdef RS232_RX_PARITY_EN
            PARITY: if (vote_now) begin
                par_bit_d = vote;
                state_d   = STOP;
            end
`endif
            STOP: if (vote_now) begin
                stop_low_d = stop_low_q | ~vote;
                if (bit_cnt_q == 4'd0) first_stop_low_d = ~vote;
                if (bit_cnt_q == LastStopIdx) begin
                    commit  = 1'b1;
                    state_d = vote ? IDLE : WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WAIT: if (s) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) valid_d = 1'b0;
        // A frame finishing while the previous one is unread is dropped, unless it is read on this very edge.
        if (commit) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                fe_d    = frame_fe;
                pe_d    = frame_pe;
                brk_d   = frame_brk;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q          <= IDLE;
            rx_meta_q        <= 1'b1;
            rx_sync_q        <= 1'b1;
            div_q            <= '0;
            tick_cnt_q       <= '0;
            smp_q            <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            stop_low_q       <= 1'b0;
            first_stop_low_q <= 1'b0;
            data_q           <= '0;
            valid_q          <= 1'b0;
            fe_q             <= 1'b0;
            pe_q             <= 1'b0;
            brk_q            <= 1'b0;
            ovr_q            <= 1'b0;
            busy_q           <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_bit_q        <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            rx_meta_q        <= rx_meta_d;
            rx_sync_q        <= rx_sync_d;
            div_q            <= div_d;
            tick_cnt_q       <= tick_cnt_d;
            smp_q            <= smp_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            stop_low_q       <= stop_low_d;
            first_stop_low_q <= first_stop_low_d;
            data_q           <= data_d;
            valid_q          <= valid_d;
            fe_q             <= fe_d;
            pe_q             <= pe_d;
            brk_q            <= brk_d;
            ovr_q            <= ovr_d;
            busy_q           <= busy_d;
`ifdef RS232_RX_PARITY_EN
            par_bit_q        <= par_bit_d;
`endif
        end
    end

    assign RxData      = data_q;
    assign RxValid     = valid_q;
    assign FrameError  = fe_q;
    assign ParityError = pe_q;
    assign Break       = brk_q;
    assign Overrun     = ovr_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_rs232_rx_param.sv
// tb_rs232_rx_param: randomized + directed bench for rs232_rx_param against a frame-level reference model.
// Define RS232_RX_PARITY_EN to exercise the parity build (7 data bits, 2 stop bits).
module tb_rs232_rx_param;

    localparam int SD  = 4;
    localparam int BIT = 16 * SD;
`ifdef RS232_RX_PARITY_EN
    localparam int DB    = 7;
    localparam int SB    = 2;
    localparam int PE_EN = 1;
`else
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int PE_EN = 0;
`endif
    localparam bit PODD = 1'b0;
    localparam int FB   = 1 + DB + PE_EN + SB;
    // The final stop vote lands at tick 9 of the last bit; the commit edge adds synchroniser and detect clocks.
    localparam int NOMINAL    = BIT * (FB - 1) + 10 * SD;
    localparam int COMMIT_LAT = NOMINAL + 3;

    typedef struct {
        logic [DB-1:0] data;
        logic          fe;
        logic          pe;
        logic          brk;
        logic          drop;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset, Rx, RxReady;
    logic [DB-1:0] RxData;
    logic          RxValid, FrameError, ParityError, Break, Overrun, Busy;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0;
    int frames_seen = 0, ovr_count = 0, last_cyc = 0;
    logic [DB-1:0] last_data;
    logic last_fe, last_pe, last_brk;
    exp_t exp_q[$];
    exp_t held;
    logic prev_valid = 1'b0, prev_acc = 1'b0;

    rs232_rx_param #(
        .SampleDiv(SD), .DivBits(8), .DataBits(DB), .StopBits(SB), .ParityOdd(0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Rx(Rx), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .FrameError(FrameError), .ParityError(ParityError), .Break(Break), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Reference model: what a frame must report, derived only from the line bits that were sent.
    function automatic exp_t model(input logic [15:0] fb, input logic drop);
        exp_t e;
        logic par, any_low;
        for (int i = 0; i < DB; i++) e.data[i] = fb[1+i];
        par     = (PE_EN != 0) ? fb[1+DB] : 1'b0;
        any_low = 1'b0;
        for (int k = 0; k < SB; k++) if (!fb[1+DB+PE_EN+k]) any_low = 1'b1;
        e.fe   = any_low;
        e.brk  = (e.data == '0) && !par && !fb[1+DB+PE_EN];
        e.pe   = (PE_EN != 0) ? (par != ((^e.data) ^ PODD)) : 1'b0;
        e.drop = drop;
        return e;
    endfunction

    task automatic applyStimulus(input logic [DB-1:0] d, input logic par_flip, input int stop_low_idx,
                                 input int gap, input logic drop);
        logic [15:0] fb;
        fb    = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < DB; i++) fb[1+i] = d[i];
        if (PE_EN != 0) fb[1+DB] = (^d) ^ PODD ^ par_flip;
        for (int k = 0; k < SB; k++) fb[1+DB+PE_EN+k] = (k != stop_low_idx);
        exp_q.push_back(model(fb, drop));
        start_cyc = cyc;
        for (int b = 0; b < FB; b++) begin
            Rx = fb[b];
            step(BIT);
        end
        Rx = 1'b1;
        step(gap);
    endtask

    // Compare process: every new frame, every held cycle and every Overrun pulse is checked against the model.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (Overrun) begin
                ovr_count++;
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].drop) begin
                    failures++;
                    $display("[TB] FAIL overrun_unexpected: got Overrun=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (RxValid && (!prev_valid || prev_acc)) begin
                frames_seen++;
                last_data = RxData;
                last_fe   = FrameError;
                last_pe   = ParityError;
                last_brk  = Break;
                last_cyc  = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_frame: got data 0x%0h, expected no frame (cycle %0d)", RxData, cyc);
                end else begin
                    e = exp_q.pop_front();
                    held = e;
                    checkOutput("rx_frame", 32'({RxData, FrameError, ParityError, Break, 1'b0}),
                                32'({e.data, e.fe, e.pe, e.brk, e.drop}));
                end
            end else if (RxValid) begin
                checkOutput("rx_hold", 32'({RxData, FrameError, ParityError, Break}),
                            32'({held.data, held.fe, held.pe, held.brk}));
            end
            prev_valid = RxValid;
            prev_acc   = RxValid && RxReady;
        end
    end

    initial begin
        repeat (80000) @(posedge Clk);
        $display("[TB] FAIL watchdog: got no end of test, expected finish within 80000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0, o0, lat, sl, gap;
        logic [DB-1:0] d;
        logic pf;

        Reset = 1'b1; Rx = 1'b1; RxReady = 1'b1;
        step(3);
        checkOutput("reset_outputs", 32'({RxData, RxValid, FrameError, ParityError, Break, Overrun, Busy}), 32'd0);
        Reset = 1'b0;
        step(8);

        n0 = frames_seen;
        applyStimulus(DB'(8'hA5), 1'b0, -1, 32, 1'b0);
        checkOutput("a5_count", frames_seen - n0, 1);
        checkOutput("a5_data", 32'(last_data), 32'(DB'(8'hA5)));
        checkOutput("a5_flags", {last_fe, last_pe, last_brk}, 0);
        lat = last_cyc - start_cyc;
        checkOutput("a5_latency_in_window", 32'((lat >= NOMINAL - 16) && (lat <= NOMINAL + 16)), 1);

        n0 = frames_seen;
        Rx = 1'b0;
        step(10);
        checkOutput("glitch_busy_high", Busy, 1);
        step(10);
        Rx = 1'b1;
        step(50);
        checkOutput("glitch_busy_low", Busy, 0);
        checkOutput("glitch_no_frame", frames_seen - n0, 0);

        applyStimulus(DB'(8'h3C), 1'b0, SB - 1, 2 * BIT, 1'b0);
        checkOutput("stop_low_data", 32'(last_data), 32'(DB'(8'h3C)));
        checkOutput("stop_low_fe_brk", {last_fe, last_brk}, 2'b10);
        applyStimulus(DB'(8'h5A), 1'b0, -1, 16, 1'b0);
        checkOutput("after_fe_clean", {last_fe, last_pe, last_brk}, 0);

        n0 = frames_seen;
        exp_q.push_back(model(16'h0000, 1'b0));
        Rx = 1'b0;
        step(30 * BIT);
        Rx = 1'b1;
        step(2 * BIT);
        checkOutput("break_one_frame", frames_seen - n0, 1);
        checkOutput("break_flags", 32'({last_data, last_fe, last_brk}), 32'({DB'(0), 2'b11}));

        RxReady = 1'b0;
        o0 = ovr_count;
        applyStimulus(DB'(8'h11), 1'b0, -1, 16, 1'b0);
        applyStimulus(DB'(8'h22), 1'b0, -1, 16, 1'b1);
        checkOutput("overrun_once", ovr_count - o0, 1);
        checkOutput("overrun_keeps_old", 32'(RxData), 32'(DB'(8'h11)));
        fork
            applyStimulus(DB'(8'h33), 1'b0, -1, 16, 1'b0);
            begin
                step(COMMIT_LAT - 1);
                RxReady = 1'b1;
            end
        join
        checkOutput("same_edge_no_overrun", ovr_count - o0, 1);
        checkOutput("same_edge_data", 32'(last_data), 32'(DB'(8'h33)));

`ifdef RS232_RX_PARITY_EN
        applyStimulus(DB'(8'h55), 1'b0, -1, 16, 1'b0);
        checkOutput("parity_ok", last_pe, 0);
        applyStimulus(DB'(8'h55), 1'b1, -1, 16, 1'b0);
        checkOutput("parity_bad", last_pe, 1);
`endif

        for (int f = 0; f < 14; f++) begin
            d   = DB'($urandom);
            pf  = (PE_EN != 0) && ($urandom_range(3) == 0);
            sl  = ($urandom_range(3) == 0) ? int'($urandom_range(SB - 1)) : -1;
            gap = (sl == SB - 1) ? 8 + int'($urandom_range(40)) : int'($urandom_range(40));
            applyStimulus(d, pf, sl, gap, 1'b0);
        end

        n0 = frames_seen;
        Rx = 1'b0;
        step(BIT);
        Rx = 1'b1;
        step(BIT);
        Rx = 1'b0;
        step(BIT / 2);
        Reset = 1'b1;
        Rx    = 1'b1;
        step(1);
        @(negedge Clk);
        checkOutput("mid_frame_reset_outputs",
                    32'({RxData, RxValid, FrameError, ParityError, Break, Overrun, Busy}), 32'd0);
        step(2);
        Reset = 1'b0;
        step(20 * BIT);
        checkOutput("mid_frame_reset_no_frame", frames_seen - n0, 0);

        step(4 * BIT);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
